// File: rtl/chip_sched_pkg.sv
// Shared definitions for the chip-test scheduler.
//   state_e        : scheduler FSM state encoding (also exported for debug)
//   N_CHIP_DEF     : default number of tester slots on the socket
//   SETTLE_CYC_DEF : default pin-mux settle time before Run
//   SEL_W          : width of the tester index bus
package chip_sched_pkg;

  localparam int N_CHIP_DEF     = 8;
  localparam int SETTLE_CYC_DEF = 4;
  localparam int SEL_W          = 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_RUN     = 3'd2,
    S_WAIT    = 3'd3,
    S_CAPTURE = 3'd4,
    S_RELEASE = 3'd5,
    S_SHOW    = 3'd6
  } state_e;

endpackage

// File: rtl/sched_timer.sv
// Loadable down-counter with a zero flag. Shared by the scheduler for the
// pin-mux settle count and the WAIT watchdog count.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_val (wins over dec)
//   load_val  : value to load
//   dec       : decrement by one, saturating at zero
//   zero      : count is zero
module sched_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/chip_test_sched.sv
// Chip-test scheduler: on a Start button edge it routes the socket pins to
// the selected tester, lets the mux settle, pulses Run, waits for Done,
// captures the pass/fail result and acknowledges it with Disp until the
// tester drops Done.
//
// Tester handshake (per selected slot): Run_o is a single-cycle request.
// The tester raises Done_i when finished and keeps it high; RSLT_i is taken
// one cycle after Done_i is first seen. Disp_o then stays high until Done_i
// is seen low, which completes the transaction. Done_i/RSLT_i of other
// slots are ignored.
//
// Ports:
//   Clk, Reset        : clock, asynchronous active-high reset
//   Start             : test button level (rising edge starts a test)
//   Sel               : tester index, sampled on the Start edge
//   Chip_Sel          : registered pin-mux select
//   Run_o / Disp_o    : one-hot Run request / result acknowledge
//   Done_i / RSLT_i   : per-tester Done and result (1 = pass)
//   Busy, Pass, Fail, Err : status flags
//   dbg_state         : current FSM state
//
// Build option: define CHIP_SCHED_TIMEOUT_EN to add a WAIT watchdog that
// ends the test with Err=1, Fail=1 after TIMEOUT_CYC cycles without Done.
module chip_test_sched
  import chip_sched_pkg::*;
#(
  parameter int N_CHIP      = N_CHIP_DEF,
  parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [SEL_W-1:0]  Sel,
  output logic [SEL_W-1:0]  Chip_Sel,
  output logic [N_CHIP-1:0] Run_o,
  input  logic [N_CHIP-1:0] Done_i,
  input  logic [N_CHIP-1:0] RSLT_i,
  output logic [N_CHIP-1:0] Disp_o,
  output logic              Busy,
  output logic              Pass,
  output logic              Fail,
  output logic              Err,
  output state_e            dbg_state
);

  // Timer is wide enough for either load so it is identical in both builds.
  localparam int TMR_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_e           state_q, state_d;
  logic             start_q, start_d;
  logic [SEL_W-1:0] chip_sel_q, chip_sel_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             err_q, err_d;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_dec;
  logic             tmr_zero;

  logic [N_CHIP-1:0] sel_oh;
  logic              sel_valid;
  logic              done_sel;
  logic              rslt_sel;
  logic              start_rise;

  // An index beyond the last slot shifts out entirely, giving an all-zero
  // mask: that both flags the select invalid and keeps Run/Disp silent.
  assign sel_oh     = N_CHIP'(1) << chip_sel_q;
  assign sel_valid  = |sel_oh;
  assign done_sel   = |(Done_i & sel_oh);
  assign rslt_sel   = |(RSLT_i & sel_oh);
  assign start_d    = Start;
  assign start_rise = Start & ~start_q;
  assign tmr_dec    = (state_q == S_ARM) || (state_q == S_WAIT);

  sched_timer #(.W(TMR_W)) u_timer (
    .clk      (Clk),
    .rst      (Reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // State and datapath registers. The edge register resets high so a
  // button held through reset release is not taken as a new press.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b1;
      chip_sel_q <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      chip_sel_q <= chip_sel_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      err_q      <= err_d;
    end
  end

  // Next state, latched select/flags and timer control.
  always_comb begin
    state_d    = state_q;
    chip_sel_d = chip_sel_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    err_d      = err_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    case (state_q)
      S_IDLE, S_SHOW: begin
        if (start_rise) begin
          chip_sel_d = Sel;
          pass_d     = 1'b0;
          fail_d     = 1'b0;
          err_d      = 1'b0;
          tmr_load   = 1'b1;
          tmr_val    = TMR_W'(SETTLE_CYC - 1);
          state_d    = S_ARM;
        end
      end
      S_ARM: begin
        if (!sel_valid) begin
          err_d   = 1'b1;
          state_d = S_SHOW;
        end else if (tmr_zero) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
`ifdef CHIP_SCHED_TIMEOUT_EN
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(TIMEOUT_CYC - 1);
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_sel) begin
          state_d = S_CAPTURE;
        end
`ifdef CHIP_SCHED_TIMEOUT_EN
        else if (tmr_zero) begin
          err_d   = 1'b1;
          fail_d  = 1'b1;
          state_d = S_SHOW;
        end
`else
`endif
      end
      S_CAPTURE: begin
        pass_d  = rslt_sel;
        fail_d  = ~rslt_sel;
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!done_sel) begin
          state_d = S_SHOW;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state only, so Run and Disp can
  // never overlap and both vanish the instant reset is asserted.
  always_comb begin
    Run_o  = '0;
    Disp_o = '0;
    Busy   = 1'b1;
    case (state_q)
      S_RUN:          Run_o  = sel_oh;
      S_RELEASE:      Disp_o = sel_oh;
      S_IDLE, S_SHOW: Busy   = 1'b0;
      default:        ;
    endcase
  end

  assign Chip_Sel  = chip_sel_q;
  assign Pass      = pass_q;
  assign Fail      = fail_q;
  assign Err       = err_q;
  assign dbg_state = state_q;

endmodule
